sbox_scheduler: RTL and testbench
=================================

SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

Interface
REQ-001 Parameter KEY_PRIO, default 1; fixed-priority winner when both requesters are pending: 1 = key-word port, 0 = state port.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 st_valid  input  1  state-port request.
REQ-005 st_ready  output  1  state-port grant; transfer occurs when st_valid & st_ready at a rising edge.
REQ-006 st_data  input  [0:127]  128-bit AES state; bits [0:7] = byte 0.
REQ-007 st_out  output  [0:127]  SubBytes result of the last completed state job.
REQ-008 st_done  output  1  one-cycle pulse, st_out newly valid.
REQ-009 kw_valid  input  1  key-expansion word request.
REQ-010 kw_ready  output  1  key-port grant; transfer on kw_valid & kw_ready.
REQ-011 kw_data  input  [0:31]  key-schedule word (after RotWord).
REQ-012 kw_out  output  [0:31]  SubWord result of the last completed key job.
REQ-013 kw_done  output  1  one-cycle pulse, kw_out newly valid.
REQ-014 sb_in  output  [0:31]  four bytes to the four external combinational sbox lanes.
REQ-015 sb_out  input  [0:31]  lane results, same byte order as sb_in, same cycle.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, ST_RUN, KW_RUN; a single 2-bit word counter wcnt.
REQ-018 st_ready/kw_ready are high only in IDLE and only for the arbitration winner; at most one is high per cycle.
REQ-019 A requester that is not valid is never granted; a sole valid requester is granted in the same IDLE cycle.
REQ-020 Accepted data is registered on the accept edge; later changes on st_data/kw_data have no effect on the job.
REQ-021 State accept -> ST_RUN with wcnt=0; during ST_RUN, sb_in = captured word wcnt (word 0 = bits [0:31]); sb_out is stored into st_out word wcnt at the edge ending that cycle; wcnt increments.
REQ-022 ST_RUN lasts exactly 4 cycles (wcnt 0..3), then -> IDLE; st_done = 1 during the first IDLE cycle (accept at end of cycle 0 -> st_done in cycle 5).
REQ-023 Key accept -> KW_RUN for 1 cycle with sb_in = captured word; sb_out stored into kw_out; -> IDLE with kw_done = 1 in that IDLE cycle (cycle 2).
REQ-024 A new grant is permitted in the same IDLE cycle that carries a done pulse (back-to-back jobs; state throughput 1 per 5 cycles, key 1 per 2).
REQ-025 sb_in = 0 in IDLE.
REQ-026 st_out/kw_out hold their value until overwritten by their own next job; a key job never alters st_out and vice versa.
REQ-027 wcnt wraps 3 -> 0 only on the ST_RUN -> IDLE transition.

Reset
REQ-028 rst_n low asynchronously forces IDLE, wcnt=0, st_out=0, kw_out=0, st_done=0, kw_done=0, busy=0, sb_in=0, and both ready signals low while rst_n is low.
REQ-029 Reset during ST_RUN or KW_RUN aborts the job; no done pulse is produced after release.
REQ-030 After rst_n is released, the first grant occurs no earlier than the first rising edge with rst_n high.

Configuration
REQ-031 Macro SBOX_SCHED_RR_EN defined: round-robin arbitration; on contention the port not granted last wins; the last-granted flag resets to "key", so the first contention grants the state port; KEY_PRIO is ignored.
REQ-032 SBOX_SCHED_RR_EN undefined: fixed priority per KEY_PRIO; no last-granted register exists.

Verification
REQ-033 State of all 0x00 accepted in cycle 0 -> st_done in cycle 5, st_out = 0x63 repeated 16 times, busy high in cycles 1-4.
REQ-034 kw_data = 0x00112233 -> kw_done in cycle 2, kw_out = 0x638293C3; st_out unchanged.
REQ-035 KEY_PRIO=1, both valid in the same cycle (state all 0x53, key 0x00000000) -> key granted first, kw_out = 0x63636363 in cycle 2; state granted in cycle 2; st_out = 0xED x16 with st_done in cycle 7.
REQ-036 SBOX_SCHED_RR_EN defined, both requesters permanently valid -> grants alternate state, key, state, key; neither port is granted twice in a row.
REQ-037 rst_n pulsed low in cycle 2 of a state job -> all outputs 0 immediately, no st_done afterwards; a new job after release completes normally.
REQ-038 Change st_data during ST_RUN -> st_out reflects only the data captured at accept.

Source files
------------

// File: rtl/sbox_scheduler.sv
// sbox_scheduler: shares four external combinational AES S-box lanes between a
// 128-bit state port (4 words over 4 cycles) and a 32-bit key-word port (1 cycle).
// Build option: define SBOX_SCHED_RR_EN for round-robin arbitration instead of KEY_PRIO.
module sbox_scheduler #(
    parameter int KEY_PRIO = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [0:127] st_data,
    output logic [0:127] st_out,
    output logic         st_done,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [0:31]  kw_data,
    output logic [0:31]  kw_out,
    output logic         kw_done,
    output logic [0:31]  sb_in,
    input  logic [0:31]  sb_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [1:0]   r_wcnt;
    logic [0:127] r_st_buf;
    logic [0:31]  r_kw_buf;
    logic [0:127] r_st_out;
    logic [0:31]  r_kw_out;
    logic         r_st_done;
    logic         r_kw_done;

    logic         w_idle;
    logic         w_st_win;
    logic         w_kw_win;
    logic         w_st_acc;
    logic         w_kw_acc;
    logic [6:0]   w_word_base;

    assign w_idle      = (r_state == IDLE);
    assign w_word_base = {r_wcnt, 5'd0};

    // Arbitration: decide which valid requester would win if the block were idle.
`ifdef SBOX_SCHED_RR_EN
    logic r_last_key;
    logic w_unused_prio;

    assign w_unused_prio = (KEY_PRIO != 0);

    always_comb begin
        w_st_win = st_valid & (~kw_valid | r_last_key);
        w_kw_win = kw_valid & (~st_valid | ~r_last_key);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_key <= 1'b1;
        end else if (w_st_acc) begin
            r_last_key <= 1'b0;
        end else if (w_kw_acc) begin
            r_last_key <= 1'b1;
        end
    end
`else
    localparam logic KEY_WINS = (KEY_PRIO != 0);

    always_comb begin
        w_st_win = st_valid & (~kw_valid | ~KEY_WINS);
        w_kw_win = kw_valid & (~st_valid | KEY_WINS);
    end
`endif

    // Grants are gated by rst_n so neither ready can rise while reset is held.
    assign w_st_acc = rst_n & w_idle & w_st_win;
    assign w_kw_acc = rst_n & w_idle & w_kw_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wcnt  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_RUN) begin
                r_wcnt <= r_wcnt + 2'd1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        sb_in        = '0;
        unique case (r_state)
            IDLE: begin
                if (w_st_acc) begin
                    w_next_state = ST_RUN;
                end else if (w_kw_acc) begin
                    w_next_state = KW_RUN;
                end
            end
            ST_RUN: begin
                sb_in = r_st_buf[w_word_base +: 32];
                if (r_wcnt == 2'd3) begin
                    w_next_state = IDLE;
                end
            end
            KW_RUN: begin
                sb_in        = r_kw_buf;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // NOTE: capture buffers carry no reset; they are only read after an accept has loaded them.
    always_ff @(posedge clk) begin
        if (w_st_acc) begin
            r_st_buf <= st_data;
        end
        if (w_kw_acc) begin
            r_kw_buf <= kw_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st_out  <= '0;
            r_kw_out  <= '0;
            r_st_done <= 1'b0;
            r_kw_done <= 1'b0;
        end else begin
            r_st_done <= (r_state == ST_RUN) && (r_wcnt == 2'd3);
            r_kw_done <= (r_state == KW_RUN);
            if (r_state == ST_RUN) begin
                r_st_out[w_word_base +: 32] <= sb_out;
            end
            if (r_state == KW_RUN) begin
                r_kw_out <= sb_out;
            end
        end
    end

    assign st_ready = w_st_acc;
    assign kw_ready = w_kw_acc;
    assign st_out   = r_st_out;
    assign kw_out   = r_kw_out;
    assign st_done  = r_st_done;
    assign kw_done  = r_kw_done;
    assign busy     = ~w_idle;

`ifndef SYNTHESIS
    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(st_ready && kw_ready));
    a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (st_ready || kw_ready) |-> (r_state == IDLE));
`endif

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb_sbox_scheduler: drives sbox_scheduler with directed and random traffic and
// compares every cycle against a job-level model using a GF(2^8) computed S-box.
module tb_sbox_scheduler;

    localparam int KEY_PRIO_TB = 1;

    logic         clk;
    logic         rst_n;
    logic         st_valid;
    logic         st_ready;
    logic [0:127] st_data;
    logic [0:127] st_out;
    logic         st_done;
    logic         kw_valid;
    logic         kw_ready;
    logic [0:31]  kw_data;
    logic [0:31]  kw_out;
    logic         kw_done;
    logic [0:31]  sb_in;
    logic [0:31]  sb_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    sbox_scheduler #(.KEY_PRIO(KEY_PRIO_TB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_data  (st_data),
        .st_out   (st_out),
        .st_done  (st_done),
        .kw_valid (kw_valid),
        .kw_ready (kw_ready),
        .kw_data  (kw_data),
        .kw_out   (kw_out),
        .kw_done  (kw_done),
        .sb_in    (sb_in),
        .sb_out   (sb_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES S-box from field arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] e;
        e = 8'hfe;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] sbox_block(input logic [0:127] d);
        logic [0:127] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox(d[i*8 +: 8]);
        return r;
    endfunction

    // The four external lanes.
    always_comb sb_out = {sbox(sb_in[0:7]), sbox(sb_in[8:15]), sbox(sb_in[16:23]), sbox(sb_in[24:31])};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- job-level reference model ----------------
    int           m_kind;      // 0 idle, 1 state job, 2 key job
    int           m_phase;     // words already processed in a state job
    logic [0:127] m_st_cap;
    logic [0:31]  m_kw_cap;
    logic [0:127] m_st_out;
    logic [0:31]  m_kw_out;
    logic         m_st_done;
    logic         m_kw_done;
`ifdef SBOX_SCHED_RR_EN
    logic         m_last_key;
`endif

    // {state wins, key wins} when idle
    function automatic logic [1:0] model_win();
        if (st_valid && kw_valid) begin
`ifdef SBOX_SCHED_RR_EN
            return m_last_key ? 2'b10 : 2'b01;
`else
            return (KEY_PRIO_TB != 0) ? 2'b01 : 2'b10;
`endif
        end
        return {st_valid, kw_valid};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [1:0] g;
        if (!rst_n) begin
            m_kind    = 0;
            m_phase   = 0;
            m_st_out  = '0;
            m_kw_out  = '0;
            m_st_done = 1'b0;
            m_kw_done = 1'b0;
`ifdef SBOX_SCHED_RR_EN
            m_last_key = 1'b1;
`endif
        end else begin
            g = (m_kind == 0) ? model_win() : 2'b00;
            m_st_done = 1'b0;
            m_kw_done = 1'b0;
            if (m_kind == 1) begin
                for (int b = 0; b < 4; b++)
                    m_st_out[m_phase*32 + b*8 +: 8] = sbox(m_st_cap[m_phase*32 + b*8 +: 8]);
                m_phase++;
                if (m_phase == 4) begin
                    m_kind    = 0;
                    m_phase   = 0;
                    m_st_done = 1'b1;
                end
            end else if (m_kind == 2) begin
                for (int b = 0; b < 4; b++) m_kw_out[b*8 +: 8] = sbox(m_kw_cap[b*8 +: 8]);
                m_kind    = 0;
                m_kw_done = 1'b1;
            end else if (g[1]) begin
                m_kind   = 1;
                m_phase  = 0;
                m_st_cap = st_data;
`ifdef SBOX_SCHED_RR_EN
                m_last_key = 1'b0;
`endif
            end else if (g[0]) begin
                m_kind   = 2;
                m_kw_cap = kw_data;
`ifdef SBOX_SCHED_RR_EN
                m_last_key = 1'b1;
`endif
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0]  w;
        logic [0:31] exp_sb;
        if (check_en) begin
            w      = (m_kind == 0 && rst_n) ? model_win() : 2'b00;
            exp_sb = '0;
            if (m_kind == 1) exp_sb = m_st_cap[m_phase*32 +: 32];
            else if (m_kind == 2) exp_sb = m_kw_cap;
            check("st_ready", st_ready, w[1]);
            check("kw_ready", kw_ready, w[0]);
            check("busy", busy, m_kind != 0);
            check("sb_in", sb_in, exp_sb);
            check("st_done", st_done, m_st_done);
            check("kw_done", kw_done, m_kw_done);
            check("st_out", st_out, m_st_out);
            check("kw_out", kw_out, m_kw_out);
        end
    end

    // ---------------- directed tasks (start and end at posedge+1) ----------------
    task automatic state_job(input logic [0:127] d, input logic [0:127] exp_out, input bit scramble);
        bit got;
        got = 1'b0;
        st_valid = 1'b1;
        st_data  = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (st_ready) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("st_grant_seen", got, 1);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        got = 1'b0;
        for (int n = 1; n <= 8 && !got; n++) begin
            if (scramble) st_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("st_busy", busy, n < 5);
            if (st_done) begin
                got = 1'b1;
                check("st_done_latency", n, 5);
                check("st_out_value", st_out, exp_out);
            end
        end
        check("st_done_seen", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic kw_job(input logic [0:31] d, input logic [0:31] exp_out, input logic [0:127] exp_st);
        bit got;
        got = 1'b0;
        kw_valid = 1'b1;
        kw_data  = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (kw_ready) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("kw_grant_seen", got, 1);
        @(posedge clk);
        #1;
        kw_valid = 1'b0;
        kw_data  = ~d;
        got = 1'b0;
        for (int n = 1; n <= 6 && !got; n++) begin
            @(negedge clk);
            if (kw_done) begin
                got = 1'b1;
                check("kw_done_latency", n, 2);
                check("kw_out_value", kw_out, exp_out);
                check("kw_keeps_st_out", st_out, exp_st);
            end
        end
        check("kw_done_seen", got, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [0:127] d;
        bit got;
        int prev;
        int cur;
        int grants;

        st_valid = 1'b0;
        kw_valid = 1'b0;
        st_data  = '0;
        kw_data  = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;

        check("sbox_00", sbox(8'h00), 8'h63);
        check("sbox_53", sbox(8'h53), 8'hed);
        check("sbox_11", sbox(8'h11), 8'h82);
        check("sbox_ff", sbox(8'hff), 8'h16);
        check("rst_st_out", st_out, 0);
        check("rst_busy", busy, 0);

        #2 check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        state_job({16{8'h00}}, {16{8'h63}}, 1'b0);
        kw_job(32'h00112233, 32'h638293c3, {16{8'h63}});

`ifndef SBOX_SCHED_RR_EN
        // Contention with key priority: key first, state right after its done pulse.
        st_valid = 1'b1;
        st_data  = {16{8'h53}};
        kw_valid = 1'b1;
        kw_data  = 32'h0;
        @(negedge clk);
        check("cont_kw_ready", kw_ready, 1);
        check("cont_st_ready", st_ready, 0);
        @(posedge clk);
        #1 kw_valid = 1'b0;
        @(negedge clk);
        check("cont_st_wait", st_ready, 0);
        @(negedge clk);
        check("cont_kw_done", kw_done, 1);
        check("cont_kw_out", kw_out, 32'h63636363);
        check("cont_st_ready_c2", st_ready, 1);
        @(posedge clk);
        #1 st_valid = 1'b0;
        got = 1'b0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (st_done) begin
                got = 1'b1;
                check("cont_st_latency", n, 5);
                check("cont_st_out", st_out, {16{8'hed}});
            end
        end
        check("cont_st_done_seen", got, 1);
        @(posedge clk);
        #1;
`else
        // Both permanently valid: grants must alternate.
        st_valid = 1'b1;
        kw_valid = 1'b1;
        st_data  = {16{8'h53}};
        kw_data  = 32'h0;
        prev = -1;
        grants = 0;
        for (int n = 0; n < 60 && grants < 8; n++) begin
            @(negedge clk);
            cur = st_ready ? 0 : (kw_ready ? 1 : -1);
            if (cur >= 0) begin
                if (prev >= 0) check("rr_alternate", cur != prev, 1);
                prev = cur;
                grants++;
            end
            @(posedge clk);
            #1;
        end
        check("rr_grant_count", grants, 8);
        st_valid = 1'b0;
        kw_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
`endif

        // Reset in cycle 2 of a state job aborts it.
        d = {$urandom, $urandom, $urandom, $urandom};
        st_valid = 1'b1;
        st_data  = d;
        @(negedge clk);
        check("abort_sole_grant", st_ready, 1);
        @(posedge clk);
        #1 st_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pre", busy, 1);
        #2;
        st_valid = 1'b1;
        kw_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("abort_st_out", st_out, 0);
        check("abort_kw_out", kw_out, 0);
        check("abort_busy", busy, 0);
        check("abort_sb_in", sb_in, 0);
        check("abort_st_ready", st_ready, 0);
        check("abort_kw_ready", kw_ready, 0);
        check("abort_dones", {st_done, kw_done}, 0);
        @(posedge clk);
        #1;
        check("abort_ready_held", {st_ready, kw_ready}, 0);
        st_valid = 1'b0;
        kw_valid = 1'b0;
        rst_n    = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("abort_no_done", st_done, 0);
        end
        @(posedge clk);
        #1;
        d = {$urandom, $urandom, $urandom, $urandom};
        state_job(d, sbox_block(d), 1'b0);

        // Input changes during the run must not leak into the result.
        d = {$urandom, $urandom, $urandom, $urandom};
        state_job(d, sbox_block(d), 1'b1);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            st_valid = ($urandom_range(0, 2) == 0);
            kw_valid = ($urandom_range(0, 3) == 0);
            st_data  = {$urandom, $urandom, $urandom, $urandom};
            kw_data  = $urandom;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            @(posedge clk);
            #1;
        end
        st_valid = 1'b0;
        kw_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
